// File: rtl/multi_8b_ctrl.sv
// Operand front-end and result back-end for the multi_8b shift-add multiplier.
// Define MULT_SIGNED_EN to treat op_a/op_b as two's complement (sign applied on capture).
module multi_8b_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        mul_inicio,
  output logic [15:0] mul_multiplicando,
  output logic [7:0]  mul_multiplicador,
  input  logic [15:0] mul_produto,
  input  logic        mul_fim,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] resultado,
  output logic        erro,
  output logic        ocupado
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_r, state_s;
  logic [7:0]  wd_r, wd_s;
  logic [7:0]  a_mag_r, b_mag_r;
  logic [7:0]  a_mag_s, b_mag_s;
  logic [15:0] prod_s;
  logic        in_ready_r, mul_inicio_r, ocupado_r, out_valid_r, erro_r;
  logic [15:0] resultado_r;

`ifdef MULT_SIGNED_EN
  logic neg_r;

  function automatic logic [7:0] mag8(input logic [7:0] v);
    mag8 = v[7] ? (8'd0 - v) : v;
  endfunction

  // Magnitudes go to the multiplier; the sign is re-applied at capture.
  always_comb begin
    a_mag_s = mag8(op_a);
    b_mag_s = mag8(op_b);
    if (neg_r) begin
      prod_s = 16'd0 - mul_produto;
    end else begin
      prod_s = mul_produto;
    end
  end

  // Sign of the product, captured together with the operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_r <= 1'b0;
    end else if (state_r == S_IDLE && in_valid) begin
      neg_r <= op_a[7] ^ op_b[7];
    end else begin
      neg_r <= neg_r;
    end
  end
`else
  // Unsigned operands pass straight through.
  always_comb begin
    a_mag_s = op_a;
    b_mag_s = op_b;
    prod_s  = mul_produto;
  end
`endif

  // Next-state and watchdog update.
  always_comb begin
    state_s = state_r;
    wd_s    = wd_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) state_s = S_START;
        else          state_s = S_IDLE;
      end
      S_START: begin
        state_s = S_WAIT;
        wd_s    = 8'd0;
      end
      S_WAIT: begin
        if (mul_fim) begin
          state_s = S_DONE;
        end else if (wd_r == WD_LAST) begin
          state_s = S_DONE;
          wd_s    = wd_r + 8'd1;
        end else begin
          state_s = S_WAIT;
          wd_s    = wd_r + 8'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_s = S_IDLE;
        else           state_s = S_DONE;
      end
      default: begin
        state_s = S_IDLE;
        wd_s    = 8'd0;
      end
    endcase
  end

  // State register; status outputs are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      wd_r         <= 8'd0;
      in_ready_r   <= 1'b1;
      mul_inicio_r <= 1'b0;
      ocupado_r    <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      wd_r         <= wd_s;
      in_ready_r   <= (state_s == S_IDLE);
      mul_inicio_r <= (state_s == S_START);
      ocupado_r    <= (state_s != S_IDLE);
      out_valid_r  <= (state_s == S_DONE);
    end
  end

  // Operand latch on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mag_r <= 8'd0;
      b_mag_r <= 8'd0;
    end else if (state_r == S_IDLE && in_valid) begin
      a_mag_r <= a_mag_s;
      b_mag_r <= b_mag_s;
    end else begin
      a_mag_r <= a_mag_r;
      b_mag_r <= b_mag_r;
    end
  end

  // Result capture: product on fim, zero with erro on watchdog expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultado_r <= 16'd0;
      erro_r      <= 1'b0;
    end else if (state_r == S_WAIT && mul_fim) begin
      resultado_r <= prod_s;
      erro_r      <= 1'b0;
    end else if (state_r == S_WAIT && wd_r == WD_LAST) begin
      resultado_r <= 16'd0;
      erro_r      <= 1'b1;
    end else begin
      resultado_r <= resultado_r;
      erro_r      <= erro_r;
    end
  end

  assign in_ready          = in_ready_r;
  assign mul_inicio        = mul_inicio_r;
  assign ocupado           = ocupado_r;
  assign out_valid         = out_valid_r;
  assign resultado         = resultado_r;
  assign erro              = erro_r;
  assign mul_multiplicando = {8'd0, a_mag_r};
  assign mul_multiplicador = b_mag_r;

endmodule

// File: tb/tb_multi_8b_ctrl.sv
// Scoreboard bench for multi_8b_ctrl with a behavioural 16b x 8b shift-add multiplier.
module tb_multi_8b_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  op_a = 8'd0;
  logic [7:0]  op_b = 8'd0;
  logic        mul_inicio;
  logic [15:0] mul_multiplicando;
  logic [7:0]  mul_multiplicador;
  logic [15:0] mul_produto;
  logic        mul_fim;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] resultado;
  logic        erro;
  logic        ocupado;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic stuck = 1'b0;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];

  multi_8b_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .mul_inicio(mul_inicio),
    .mul_multiplicando(mul_multiplicando), .mul_multiplicador(mul_multiplicador),
    .mul_produto(mul_produto), .mul_fim(mul_fim), .out_valid(out_valid),
    .out_ready(out_ready), .resultado(resultado), .erro(erro), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  // Behavioural multi_8b: load on inicio, then 8 shift-add steps, fim as a level.
  logic [15:0] m_acc, m_cand;
  logic [7:0]  m_plier;
  logic [3:0]  m_cnt;
  logic        m_fim;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc <= 16'd0; m_cand <= 16'd0; m_plier <= 8'd0; m_cnt <= 4'd0; m_fim <= 1'b0;
    end else if (mul_inicio) begin
      m_acc <= 16'd0; m_cand <= mul_multiplicando; m_plier <= mul_multiplicador;
      m_cnt <= 4'd8; m_fim <= 1'b0;
    end else if (m_cnt != 4'd0) begin
      if (m_plier[0]) m_acc <= m_acc + m_cand;
      m_cand  <= m_cand << 1;
      m_plier <= m_plier >> 1;
      m_cnt   <= m_cnt - 4'd1;
      if (m_cnt == 4'd1) m_fim <= 1'b1;
    end
  end
  assign mul_produto = m_acc;
  assign mul_fim     = m_fim & ~stuck;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares against the scoreboard when out_valid rises, then checks hold.
  initial begin
    logic        prev_ov;
    logic [15:0] hold_res;
    exp_t        e;
    prev_ov  = 1'b0;
    hold_res = 16'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("resultado", {16'd0, resultado}, {16'd0, e.res});
            chk("erro", {31'd0, erro}, {31'd0, e.err});
            chk("latency", cyc - e.acc, e.lat);
            hold_res = resultado;
          end
        end else if (out_valid) begin
          chk("resultado_held", {16'd0, resultado}, {16'd0, hold_res});
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] r, input logic e, input int lat);
    exp_t x;
    wait_ready();
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      op_a = a; op_b = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      x.res = r; x.err = e; x.lat = lat; x.acc = cyc;
      q.push_back(x);
      chk("inicio_high", {31'd0, mul_inicio}, 32'd1);
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      chk("ocupado_busy", {31'd0, ocupado}, 32'd1);
      @(posedge clk); #1;
      chk("inicio_one_cycle", {31'd0, mul_inicio}, 32'd0);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain", q.size(), 32'd0);
    wait_ready();
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inicio", {31'd0, mul_inicio}, 32'd0);
    chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("rst_resultado", {16'd0, resultado}, 32'd0);
    chk("rst_erro", {31'd0, erro}, 32'd0);
    rst = 1'b0;

    do_op(8'd13, 8'd11, 16'd143, 1'b0, 10);
    drain();
`ifdef MULT_SIGNED_EN
    do_op(8'hFB, 8'd7, 16'hFFDD, 1'b0, 10);
    do_op(8'h80, 8'h80, 16'h4000, 1'b0, 10);
    do_op(8'd127, 8'hFF, 16'hFF81, 1'b0, 10);
    drain();
`else
    do_op(8'd255, 8'd255, 16'hFE01, 1'b0, 10);
    do_op(8'd0, 8'd200, 16'h0000, 1'b0, 10);
    drain();
`endif

    // Consumer stalls for 20 cycles with the result presented.
    out_ready = 1'b0;
    do_op(8'd9, 8'd6, 16'd54, 1'b0, 10);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("stall_out_valid_seen", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid_high", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", {31'd0, out_valid}, 32'd0);
    drain();

    // Stuck multiplier: watchdog aborts.
    stuck = 1'b1;
    do_op(8'd3, 8'd4, 16'd0, 1'b1, 17);
    drain();
    stuck = 1'b0;
    do_op(8'd5, 8'd5, 16'd25, 1'b0, 10);
    drain();

    // Reset while waiting on the multiplier.
    do_op(8'd100, 8'd2, 16'd200, 1'b0, 10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_inicio", {31'd0, mul_inicio}, 32'd0);
    chk("midrst_ocupado", {31'd0, ocupado}, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    do_op(8'd6, 8'd7, 16'd42, 1'b0, 10);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
